// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: instruction fetch over a req/ack handshake into the IR with MIPS field decode; optional IR_NOP_ON_ERR_EN forces IR to NOP on an aborted fetch
module ir_fetch_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_start,
   input  logic [31:0] pc,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] ir,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] jaddr,
   output logic        ir_valid,
   output logic        busy,
   output logic        fetch_err
);
`ifdef IR_NOP_ON_ERR_EN
   localparam bit NOP_ON_ERR = 1'b1;
`else
   localparam bit NOP_ON_ERR = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
   state_t state;
   logic [7:0] cnt;
   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign funct  = ir[5:0];
   assign imm16  = ir[15:0];
   assign jaddr  = ir[25:0];
   // fetch FSM: IDLE and ERR both accept a new request; WAIT holds mem_rd until ack or timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         busy      <= 1'b0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         case (state)
            IDLE, ERR: if (fetch_start) begin
               ir_valid <= 1'b0;
               if (pc[1:0] != 2'b00) begin
                  state     <= ERR;
                  fetch_err <= 1'b1;
                  if (NOP_ON_ERR) ir <= '0;
               end else begin
                  state     <= WAIT;
                  mem_addr  <= pc;
                  mem_rd    <= 1'b1;
                  busy      <= 1'b1;
                  fetch_err <= 1'b0;
                  cnt       <= '0;
               end
            end
            WAIT: if (mem_ack) begin
               state    <= IDLE;
               ir       <= mem_rdata;
               ir_valid <= 1'b1;
               mem_rd   <= 1'b0;
               busy     <= 1'b0;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               state     <= ERR;
               fetch_err <= 1'b1;
               mem_rd    <= 1'b0;
               busy      <= 1'b0;
               if (NOP_ON_ERR) ir <= '0;
            end else begin
               cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/ir_fetch_unit.md
# ir_fetch_unit

Instruction fetch and instruction register stage for the multicycle datapath. On request from the control unit it reads one 32-bit word from instruction memory at `pc` over a request/acknowledge handshake, latches it into the IR, and decodes the fixed MIPS fields. Its `imm16` output feeds the sign-extension unit, and its other fields feed the register file and control unit.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum wait cycles for `mem_ack` before the fetch is aborted (1..255).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_start`  in  1  one-cycle request from control unit to fetch at `pc`.
- `pc`  in  32  fetch address, sampled in the `fetch_start` cycle.
- `mem_addr`  out  32  address presented to instruction memory.
- `mem_rd`  out  1  memory read request.
- `mem_rdata`  in  32  memory read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  memory acknowledge for the current request.
- `ir`  out  32  latched instruction word.
- `opcode`  out  6  `ir[31:26]`.
- `rs`, `rt`, `rd`  out  5 each  `ir[25:21]`, `ir[20:16]`, `ir[15:11]`.
- `shamt`  out  5  `ir[10:6]`.
- `funct`  out  6  `ir[5:0]`.
- `imm16`  out  16  `ir[15:0]`, drives the sign-extension unit.
- `jaddr`  out  26  `ir[25:0]`.
- `ir_valid`  out  1  `ir` holds a successfully fetched word.
- `busy`  out  1  a fetch is in progress.
- `fetch_err`  out  1  the last fetch aborted (misaligned or timeout).

## Operation
- FSM states: IDLE, WAIT, ERR.
- **IDLE**
  - On `fetch_start`:
    - If `pc[1:0]`≠0: go to ERR.
    - Otherwise: latch `pc` into `mem_addr`, clear `ir_valid` and `fetch_err`, load the wait counter with 0, and go to WAIT.
- **WAIT**
  - `mem_rd`=1 and `busy`=1.
  - If `mem_ack`=1: load `ir` from `mem_rdata`, set `ir_valid`=1, and go to IDLE.
  - Else if counter = `TIMEOUT`-1: go to ERR.
  - Else: increment the counter.
- **ERR**
  - `fetch_err`=1 and `ir_valid`=0; stays in ERR.
  - A new `fetch_start` leaves ERR and is handled exactly as it is in IDLE.
- `fetch_start` received while in WAIT is ignored; no queueing.
- `mem_ack` received outside WAIT is ignored.
- `ir` is unchanged by anything other than a successful ack or the configuration option below.
- Field outputs are pure slices of `ir` and change only when `ir` changes.
- Reset values:
  - State IDLE.
  - `ir`=0, so all field outputs are 0.
  - `mem_addr`=0, `mem_rd`=0, `ir_valid`=0, `busy`=0, `fetch_err`=0, counter=0.
- Reset in any state, including mid-WAIT, takes priority over all other inputs. It abandons the request, and `mem_rd` drops in the cycle after the reset edge.

## Timing
- `mem_rd`, `busy`, and `mem_addr` are registered. They assert in the cycle after `fetch_start` is sampled.
- Zero-wait memory (ack in the first WAIT cycle):
  - `ir` and `ir_valid` update on the edge ending that cycle.
  - Total latency is 2 cycles from `fetch_start` to `ir_valid`=1.
- Ack arriving in the n-th WAIT cycle (n ≤ `TIMEOUT`): `ir_valid` rises after n+1 cycles.
- Timeout: `fetch_err` rises after `TIMEOUT`+1 cycles with `mem_rd` deasserted the same edge.
- Misaligned `pc`: `fetch_err` rises one cycle after `fetch_start`. `mem_rd` is never asserted.
- Ack in the same cycle the counter reaches `TIMEOUT`-1: the ack wins and the word is latched.
- `mem_rd` is held continuously through WAIT. Memory must not ack more than once per request.

## Configuration
- `IR_NOP_ON_ERR_EN`
  - Defined: on entry to ERR, `ir` is loaded with 32'h00000000 (sll $0,$0,0, i.e. NOP). All fields therefore read 0, so a control unit that ignores `fetch_err` executes a harmless NOP.
  - Not defined: `ir` retains the last successfully fetched word through ERR.
- In both cases `ir_valid`=0 in ERR.

## Test plan
- **Reset and idle:** hold `reset`, then release with no stimulus → all outputs 0 and state IDLE for 10 cycles.
- **Zero-wait fetch:** `fetch_start` with `pc`=32'h00000040; memory acks immediately with 32'h2128FFFC (addi $8,$9,-4).
  - Cycle +1: `mem_addr`=0x40, `mem_rd`=1.
  - Cycle +2: `ir_valid`=1, `opcode`=6'h08, `rs`=9, `rt`=8, `imm16`=16'hFFFC, `busy`=0.
- **Wait states and ignored start:** ack after 3 WAIT cycles, with a second `fetch_start` issued mid-wait → only one request; `ir_valid` at cycle +4; `ir` equals the acked word.
- **Timeout:** `TIMEOUT`=4, no ack → `mem_rd` high for 4 cycles, then `fetch_err`=1 and `mem_rd`=0; `ir` holds the old word, or 0 with `IR_NOP_ON_ERR_EN`.
- **Misaligned address:** `pc`=32'h00000042 → `fetch_err`=1 at cycle +1; `mem_rd` never asserted. A following aligned `fetch_start` then clears `fetch_err` and completes normally.
- **Reset mid-WAIT:** assert `reset` in the 2nd WAIT cycle → next cycle IDLE, `mem_rd`=0, `ir`=0. A late ack afterwards leaves `ir`=0 and `ir_valid`=0.
